// File: rtl/lbm_pkg.sv
// Shared D2Q9 constants: lattice defaults, lane geometry, velocity set and
// the enumerations used by the streaming stage.
package lbm_pkg;

  localparam int Q          = 9;
  localparam int FWIDTH     = 32;
  localparam int LATTICE_NX = 16;
  localparam int LATTICE_NY = 16;

  typedef logic signed [1:0] vel_t;

  // Lattice velocities indexed by direction number.
  localparam vel_t CX [0:Q-1] = '{2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb00,
                                  2'sb01, 2'sb11, 2'sb11, 2'sb01};
  localparam vel_t CY [0:Q-1] = '{2'sb00, 2'sb00, 2'sb01, 2'sb00, 2'sb11,
                                  2'sb01, 2'sb01, 2'sb11, 2'sb11};

  typedef enum logic [3:0] {
    DIR_REST, DIR_E, DIR_N, DIR_W, DIR_S, DIR_NE, DIR_NW, DIR_SW, DIR_SE
  } dir_e;

  typedef enum logic [2:0] {
    IDLE, FETCH, LAST, WRITE, DONE
  } stream_state_e;

endpackage

// File: rtl/lbm_neighbor_addr.sv
// Upstream neighbour address for the pull scheme: node (x,y) pulls direction
// k from (x-cx, y-cy). Periodic wrap falls out of power-of-two truncation.
module lbm_neighbor_addr
  import lbm_pkg::*;
#(
  parameter int NX = LATTICE_NX,
  parameter int NY = LATTICE_NY,
  localparam int XW = $clog2(NX),
  localparam int YW = $clog2(NY)
) (
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic [3:0]       k,
  output logic [XW+YW-1:0] address
);

  vel_t          cx;
  vel_t          cy;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;

  // Subtract the sign-extended velocity and let the narrow width do the wrap.
  always_comb begin
    cx = '0;
    cy = '0;
    if (k < 4'(Q)) begin
      cx = CX[k];
      cy = CY[k];
    end
    sx      = x - XW'(cx);
    sy      = y - YW'(cy);
    address = {sy, sx};
  end

endmodule

// File: rtl/lbm_stream_pull.sv
// D2Q9 streaming stage: sweeps every node, gathers the nine distributions
// from their upstream neighbours (one RAM read per direction) and writes the
// assembled word to the destination buffer. 11 cycles per node.
module lbm_stream_pull
  import lbm_pkg::*;
#(
  parameter int NX            = LATTICE_NX,
  parameter int NY            = LATTICE_NY,
  parameter int DEPTH         = NX * NY,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int FWIDTH        = lbm_pkg::FWIDTH,
  parameter int DATA_WIDTH    = FWIDTH * Q
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [ADDRESS_WIDTH-1:0]     src_address,
  input  logic signed [DATA_WIDTH-1:0] src_data_out,
  output logic [ADDRESS_WIDTH-1:0]     dst_address,
  output logic                         dst_WE,
  output logic signed [DATA_WIDTH-1:0] dst_data_in
);

  localparam int XW = $clog2(NX);
  localparam int YW = $clog2(NY);

  stream_state_e state, stateNext;
  logic [XW-1:0] x, xNext;
  logic [YW-1:0] y, yNext;
  logic [3:0]    k, kNext;

  logic [FWIDTH-1:0] lanes     [Q];
  logic [FWIDTH-1:0] lanesNext [Q];
  logic [FWIDTH-1:0] srcLane   [Q];

  logic                         busyNext;
  logic                         doneNext;
  logic                         weNext;
  logic [ADDRESS_WIDTH-1:0]     dstAddrNext;
  logic signed [DATA_WIDTH-1:0] dstDataNext;
  logic [3:0]                   laneIdx;
  logic                         lastNode;

  // The read address follows the current node and direction counter directly,
  // so read data for direction k arrives while k+1 is being issued.
  lbm_neighbor_addr #(
    .NX(NX),
    .NY(NY)
  ) uNeighbor (
    .x      (x),
    .y      (y),
    .k      (k),
    .address(src_address)
  );

  // Lane view of the source word.
  always_comb begin
    for (int i = 0; i < Q; i++) begin
      srcLane[i] = src_data_out[FWIDTH*i +: FWIDTH];
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    stateNext   = state;
    xNext       = x;
    yNext       = y;
    kNext       = k;
    lanesNext   = lanes;
    busyNext    = busy;
    doneNext    = 1'b0;
    weNext      = 1'b0;
    dstAddrNext = dst_address;
    dstDataNext = dst_data_in;
    laneIdx     = k - 4'd1;
    lastNode    = (x == XW'(NX - 1)) && (y == YW'(NY - 1));

    case (state)
      IDLE: begin
        if (start) begin
          stateNext = FETCH;
          xNext     = '0;
          yNext     = '0;
          kNext     = '0;
          busyNext  = 1'b1;
        end
      end
      FETCH: begin
        if (k != 4'd0) begin
          lanesNext[laneIdx] = srcLane[laneIdx];
        end
        if (k == DIR_SE) begin
          stateNext = LAST;
        end else begin
          kNext = k + 4'd1;
        end
      end
      LAST: begin
        lanesNext[Q-1] = srcLane[Q-1];
        weNext         = 1'b1;
        dstAddrNext    = ADDRESS_WIDTH'({y, x});
        for (int i = 0; i < Q; i++) begin
          dstDataNext[FWIDTH*i +: FWIDTH] = lanesNext[i];
        end
        stateNext = WRITE;
      end
      WRITE: begin
        kNext = '0;
        xNext = x + 1'b1;
        if (x == XW'(NX - 1)) begin
          yNext = y + 1'b1;
        end
        stateNext = lastNode ? DONE : FETCH;
      end
      DONE: begin
        doneNext  = 1'b1;
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, counters, assembly register and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      k           <= '0;
      for (int i = 0; i < Q; i++) begin
        lanes[i] <= '0;
      end
      busy        <= 1'b0;
      done        <= 1'b0;
      dst_WE      <= 1'b0;
      dst_address <= '0;
      dst_data_in <= '0;
    end else begin
      state       <= stateNext;
      x           <= xNext;
      y           <= yNext;
      k           <= kNext;
      lanes       <= lanesNext;
      busy        <= busyNext;
      done        <= doneNext;
      dst_WE      <= weNext;
      dst_address <= dstAddrNext;
      dst_data_in <= dstDataNext;
    end
  end

endmodule

// File: tb/tb_lbm_stream_pull.sv
// Bench for lbm_stream_pull: source/destination RAM models, a pull-rule
// reference model over whole sweeps, hand-derived tagged vectors, timing and
// reset corner cases.
module tb_lbm_stream_pull;

  localparam int NX        = 16;
  localparam int NY        = 16;
  localparam int NODES     = NX * NY;
  localparam int FW        = 32;
  localparam int Q         = 9;
  localparam int DW        = FW * Q;
  localparam int AW        = 8;
  localparam int FIRST_WE  = 11;
  localparam int DONE_OFF  = NODES * 11 + 2;
  localparam int BUSY_LAST = DONE_OFF - 1;
  localparam int WINDOW    = DONE_OFF + 42;

  int cxTab [Q] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int cyTab [Q] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  typedef struct {
    int          x;
    int          y;
    int          lane;
    logic [31:0] expected;
  } vec_t;

  logic                 Clk = 1'b0;
  logic                 Reset_n = 1'b0;
  logic                 start = 1'b0;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        src_address;
  logic signed [DW-1:0] src_data_out;
  logic [AW-1:0]        dst_address;
  logic                 dst_WE;
  logic signed [DW-1:0] dst_data_in;

  logic [DW-1:0] srcMem [NODES];
  logic [DW-1:0] dstMem [NODES];

  int vectorsApplied = 0;
  int miscompares    = 0;
  int edgeCnt        = 0;
  int startEdge      = 0;
  bit monitorOn      = 1'b0;
  int monOff;
  int weCount, doneCount, firstWeOff, doneOff, busyErrors;

  lbm_stream_pull dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .src_address (src_address),
    .src_data_out(src_data_out),
    .dst_address (dst_address),
    .dst_WE      (dst_WE),
    .dst_data_in (dst_data_in)
  );

  // 10-time-unit clock.
  always #5 Clk = ~Clk;

  // Edge counter used to express timing relative to the accepted start.
  always @(posedge Clk) edgeCnt++;

  // Source RAM with registered read.
  always @(posedge Clk) src_data_out <= srcMem[src_address];

  // Destination RAM and sweep monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    if (monitorOn) begin
      monOff = edgeCnt - startEdge + 1;
      if (dst_WE) begin
        weCount++;
        if (firstWeOff < 0) firstWeOff = monOff;
        dstMem[dst_address] = dst_data_in;
      end
      if (done) begin
        doneCount++;
        doneOff = monOff;
      end
      if (busy !== (monOff >= 1 && monOff <= BUSY_LAST)) busyErrors++;
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] expectedWord(input int x, input int y);
    logic [DW-1:0] w;
    int sx, sy;
    w = '0;
    for (int i = 0; i < Q; i++) begin
      sx = ((x - cxTab[i]) % NX + NX) % NX;
      sy = ((y - cyTab[i]) % NY + NY) % NY;
      w[FW*i +: FW] = srcMem[sy*NX + sx][FW*i +: FW];
    end
    return w;
  endfunction

  task automatic fillTagged();
    for (int a = 0; a < NODES; a++)
      for (int i = 0; i < Q; i++)
        srcMem[a][FW*i +: FW] = {16'(a), 16'(i)};
  endtask

  task automatic fillRandom();
    for (int a = 0; a < NODES; a++)
      for (int i = 0; i < Q; i++)
        srcMem[a][FW*i +: FW] = $urandom;
  endtask

  task automatic clearMonitor();
    weCount = 0;
    doneCount = 0;
    firstWeOff = -1;
    doneOff = -1;
    busyErrors = 0;
    for (int a = 0; a < NODES; a++) dstMem[a] = '1;
  endtask

  task automatic launchSweep();
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    #1;
    startEdge = edgeCnt;
    start = 1'b0;
    monitorOn = 1'b1;
  endtask

  // Full sweep window; extra start pulses land in the given offset cycles.
  task automatic applyStimulus(input int spurA, input int spurB, input int spurC);
    int off;
    clearMonitor();
    launchSweep();
    repeat (WINDOW) begin
      @(negedge Clk);
      off = edgeCnt - startEdge + 1;
      start = (off == spurA) || (off == spurB) || (off == spurC);
    end
    start = 1'b0;
    monitorOn = 1'b0;
  endtask

  task automatic checkSweep(input string tag);
    checkOutput({tag, " first dst_WE offset"}, firstWeOff, FIRST_WE);
    checkOutput({tag, " dst_WE count"}, weCount, NODES);
    checkOutput({tag, " done count"}, doneCount, 1);
    checkOutput({tag, " done offset"}, doneOff, DONE_OFF);
    checkOutput({tag, " busy errors"}, busyErrors, 0);
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++)
        checkOutput($sformatf("%s node(%0d,%0d)", tag, x, y),
                    dstMem[y*NX + x], expectedWord(x, y));
  endtask

  initial begin
    vec_t vecs [10];
    int idleWe, idleBusy;
    logic [31:0] got;

    vecs[0] = '{x: 3,  y: 4,  lane: 1, expected: 32'h0042_0001};
    vecs[1] = '{x: 3,  y: 4,  lane: 2, expected: 32'h0033_0002};
    vecs[2] = '{x: 3,  y: 4,  lane: 0, expected: 32'h0043_0000};
    vecs[3] = '{x: 0,  y: 0,  lane: 5, expected: 32'h00FF_0005};
    vecs[4] = '{x: 0,  y: 0,  lane: 3, expected: 32'h0001_0003};
    vecs[5] = '{x: 0,  y: 0,  lane: 4, expected: 32'h0010_0004};
    vecs[6] = '{x: 0,  y: 0,  lane: 6, expected: 32'h00F1_0006};
    vecs[7] = '{x: 0,  y: 0,  lane: 7, expected: 32'h0011_0007};
    vecs[8] = '{x: 0,  y: 0,  lane: 8, expected: 32'h001F_0008};
    vecs[9] = '{x: 15, y: 15, lane: 7, expected: 32'h0000_0007};

    for (int a = 0; a < NODES; a++) srcMem[a] = '0;

    // Reset and idle behaviour.
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset dst_WE", dst_WE, 0);
    checkOutput("reset src_address", src_address, 0);
    checkOutput("reset dst_address", dst_address, 0);
    checkOutput("reset dst_data_in", dst_data_in, 0);
    idleWe = 0;
    idleBusy = 0;
    repeat (20) begin
      @(negedge Clk);
      if (dst_WE) idleWe++;
      if (busy) idleBusy++;
    end
    checkOutput("idle dst_WE cycles", idleWe, 0);
    checkOutput("idle busy cycles", idleBusy, 0);

    // Tagged sweep with hand-derived lane vectors.
    fillTagged();
    applyStimulus(0, 0, 0);
    checkSweep("tagged");
    for (int i = 0; i < 10; i++) begin
      got = dstMem[vecs[i].y*NX + vecs[i].x][FW*vecs[i].lane +: FW];
      checkOutput($sformatf("tagged vec (%0d,%0d) lane %0d", vecs[i].x, vecs[i].y,
                            vecs[i].lane), got, vecs[i].expected);
    end

    // Random data; starts during the sweep and in the DONE cycle are ignored.
    fillRandom();
    applyStimulus(5, 1000, BUSY_LAST);
    checkSweep("spurious");

    // Reset mid-FETCH of node 100, then a fresh full sweep.
    fillRandom();
    clearMonitor();
    launchSweep();
    repeat (100 * 11 + 5) @(negedge Clk);
    checkOutput("writes before reset", weCount, 100);
    checkOutput("busy before reset", busy, 1);
    monitorOn = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset dst_WE", dst_WE, 0);
    checkOutput("midreset src_address", src_address, 0);
    checkOutput("midreset dst_address", dst_address, 0);
    checkOutput("midreset dst_data_in", dst_data_in, 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    idleWe = 0;
    idleBusy = 0;
    repeat (40) begin
      @(negedge Clk);
      if (dst_WE) idleWe++;
      if (busy) idleBusy++;
    end
    checkOutput("post-reset dst_WE cycles", idleWe, 0);
    checkOutput("post-reset busy cycles", idleBusy, 0);
    fillRandom();
    applyStimulus(0, 0, 0);
    checkSweep("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
